// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   Oversampling UART receiver. Deserializes start(0) + DATA_WIDTH data bits
//   (LSB first) + optional parity + one stop(1) bit. Each bit is resolved by a
//   2-of-3 majority of the samples taken at edges P/2-1, P/2 and P/2+1 of that
//   bit. Parity and stop bit are checked, and the result is reported once per
//   frame on the final stop-bit edge.
//
// Ports
//   CLK        oversampling clock, Prescale cycles per bit
//   RST        asynchronous active-low reset
//   RX_IN      serial line, already synchronized to CLK, idle high
//   PAR_EN     frame carries a parity bit (latched at start detection)
//   PAR_TYP    0 = even, 1 = odd parity (latched at start detection)
//   Prescale   oversampling ratio 8/16/32 (latched at start detection)
//   P_DATA     last good received word, held until the next good frame
//   data_valid one-cycle pulse, P_DATA has just been updated
//   par_err    one-cycle pulse, parity mismatch
//   stp_err    one-cycle pulse, stop bit sampled as 0
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

    state_t                  state;
    state_t                  next_state;
    logic [5:0]              edge_cnt;
    logic [2:0]              bit_cnt;
    logic [5:0]              p_lat;
    logic                    pen_lat;
    logic                    typ_lat;
    logic [1:0]              smp;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    par_fail;
    logic                    stp_fail;

    logic [5:0]              half;
    logic                    samp_edge;
    logic                    maj_edge;
    logic                    last_edge;
    logic                    maj;

    assign half      = {1'b0, p_lat[5:1]};
    // The first two samples are stored; the third is the live line value at
    // the majority edge, so the bit is resolved on edge P/2+1 itself.
    assign samp_edge = (edge_cnt == half - 6'd1) || (edge_cnt == half);
    assign maj_edge  = (edge_cnt == half + 6'd1);
    assign last_edge = (edge_cnt == p_lat - 6'd1);
    assign maj       = (smp[1] & smp[0]) | (smp[1] & RX_IN) | (smp[0] & RX_IN);

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!RX_IN) begin
                    next_state = START;
                end
            end
            START: begin
                if (maj_edge && maj) begin
                    next_state = IDLE;
                end else if (last_edge) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (last_edge && (bit_cnt == LAST_BIT)) begin
                    next_state = pen_lat ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (last_edge) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (last_edge) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Bit timing, configuration latch and sampling
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            p_lat    <= 6'd8;
            pen_lat  <= 1'b0;
            typ_lat  <= 1'b0;
            smp      <= '0;
        end else if (state == IDLE) begin
            bit_cnt <= '0;
            if (!RX_IN) begin
                // The detecting edge is edge 0 of the start bit.
                edge_cnt <= 6'd1;
                p_lat    <= Prescale;
                pen_lat  <= PAR_EN;
                typ_lat  <= PAR_TYP;
            end else begin
                edge_cnt <= '0;
            end
        end else begin
            if (last_edge || (next_state == IDLE)) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + 6'd1;
            end
            if (samp_edge) begin
                smp <= {smp[0], RX_IN};
            end
            if ((state == DATA) && last_edge) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // Data path, error flags and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg      <= '0;
            par_fail   <= 1'b0;
            stp_fail   <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            if ((state == IDLE) && !RX_IN) begin
                par_fail <= 1'b0;
                stp_fail <= 1'b0;
            end

            if (maj_edge) begin
                case (state)
                    DATA:    shreg <= {maj, shreg[DATA_WIDTH-1:1]};
                    PARITY:  if (maj != ((^shreg) ^ typ_lat)) par_fail <= 1'b1;
                    STOP:    if (!maj) stp_fail <= 1'b1;
                    default: ;
                endcase
            end

            if ((state == STOP) && last_edge) begin
                par_err    <= par_fail;
                stp_err    <= stp_fail;
                data_valid <= !(par_fail || stp_fail);
                if (!(par_fail || stp_fail)) begin
                    P_DATA <= shreg;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .Prescale  (Prescale),
        .P_DATA    (P_DATA),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  pd;
        logic        dv;
        logic        pe;
        logic        se;
        int unsigned at;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] good = 8'h00;   // model of the last good word

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [5:0] rand_p();
        int unsigned r;
        r = $urandom_range(0, 2);
        return (r == 0) ? 6'd8 : (r == 1) ? 6'd16 : 6'd32;
    endfunction

    // Sends one frame starting at the current negedge. The expected report is
    // derived from frame content alone: parity error when the sent parity bit
    // differs from (odd popcount) xor PAR_TYP, stop error when stop bit is 0.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input int p, input logic pbit, input logic stop,
                              input int noise_bit);
        logic [10:0] bits;
        int          n;
        exp_t        e;
        logic        want_par;
        want_par = ($countones(d) % 2 == 1) ^ ptyp;
        n = pen ? 11 : 10;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        if (pen) begin
            bits[9]  = pbit;
            bits[10] = stop;
        end else begin
            bits[9] = stop;
        end
        e.pe = pen && (pbit != want_par);
        e.se = !stop;
        e.dv = !(e.pe || e.se);
        if (e.dv) good = d;
        e.pd = good;
        e.at = cyc + n * p;
        q.push_back(e);

        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        Prescale = 6'(p);
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < p; k++) begin
                RX_IN = (noise_bit >= 0 && b == noise_bit + 1 && k == p / 2) ? ~bits[b] : bits[b];
                @(negedge CLK);
                if (b == 0 && k == 0) begin
                    // configuration must be ignored once the frame has started
                    PAR_EN   = 1'($urandom);
                    PAR_TYP  = 1'($urandom);
                    Prescale = rand_p();
                end
            end
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // Monitor: every pulse must match the head of the scoreboard queue.
    always @(negedge CLK) begin
        if (RST && (data_valid || par_err || stp_err)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse dv=%0b pe=%0b se=%0b required=none (cycle %0d)",
                         data_valid, par_err, stp_err, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("data_valid", 32'(data_valid), 32'(e.dv));
                chk("par_err",    32'(par_err),    32'(e.pe));
                chk("stp_err",    32'(stp_err),    32'(e.se));
                chk("P_DATA",     32'(P_DATA),     32'(e.pd));
                chk("pulse_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_P_DATA",     32'(P_DATA),     32'h0);
        chk("rst_data_valid", 32'(data_valid), 32'h0);
        chk("rst_par_err",    32'(par_err),    32'h0);
        chk("rst_stp_err",    32'(stp_err),    32'h0);
        RST = 1'b1;
        idle(4);

        // Directed frames
        send_frame(8'hA5, 1'b0, 1'b0, 8,  1'b0, 1'b1, -1);
        idle(3);
        send_frame(8'h37, 1'b1, 1'b0, 16, 1'b1, 1'b1, -1);
        idle(3);
        send_frame(8'h37, 1'b1, 1'b0, 16, 1'b0, 1'b1, -1);   // parity error
        idle(3);
        send_frame(8'h37, 1'b1, 1'b1, 16, 1'b0, 1'b1, -1);   // odd parity, good
        idle(3);
        send_frame(8'h3C, 1'b0, 1'b0, 8,  1'b0, 1'b0, -1);   // stop error
        idle(3);
        // Start glitch: two low cycles only
        Prescale = 6'd8;
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        idle(40);
        // Noise at the middle sample of data bit 3, then back-to-back frames
        send_frame(8'h96, 1'b0, 1'b0, 32, 1'b0, 1'b1, 3);
        send_frame(8'h00, 1'b0, 1'b0, 32, 1'b0, 1'b1, -1);
        send_frame(8'hFF, 1'b0, 1'b0, 32, 1'b0, 1'b1, -1);
        idle(3);

        // Reset mid-frame
        Prescale = 6'd16;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (16) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (40) @(negedge CLK);
        RST = 1'b0;
        good = 8'h00;
        #1;
        chk("midrst_P_DATA",     32'(P_DATA),     32'h0);
        chk("midrst_data_valid", 32'(data_valid), 32'h0);
        chk("midrst_par_err",    32'(par_err),    32'h0);
        chk("midrst_stp_err",    32'(stp_err),    32'h0);
        idle(3);
        RST = 1'b1;
        idle(3);
        send_frame(8'h5A, 1'b0, 1'b0, 16, 1'b0, 1'b1, -1);
        idle(2);

        // Randomized frames
        for (int i = 0; i < 30; i++) begin
            logic [7:0] d;
            logic       pen, ptyp, pbit, stop;
            int         p, nb;
            d    = 8'($urandom);
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            p    = int'(rand_p());
            pbit = (($countones(d) % 2 == 1) ^ ptyp) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 5) != 0);
            nb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            send_frame(d, pen, ptyp, p, pbit, stop, nb);
            idle(int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge CLK);
        chk("queue_drained", 32'(q.size()), 32'h0);
        idle(50);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
